// File: rtl/kgp_seq_pkg.sv
// Shared types and constants for the KGP-RISC multi-cycle sequencer.
// Holds the state encoding, opcode values, error codes and the opcode classifier.
package kgp_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED,
        S_ERROR
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_LW,
        CLS_SW,
        CLS_BR
    } op_cls_e;

    localparam logic [5:0] OP_ALU_R = 6'b000000;
    localparam logic [5:0] OP_ALU_I = 6'b000001;
    localparam logic [5:0] OP_LW    = 6'b000010;
    localparam logic [5:0] OP_SW    = 6'b000011;
    localparam logic [5:0] OP_BR    = 6'b000100;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef struct packed {
        logic    legal;
        logic    halt;
        op_cls_e cls;
    } op_dec_t;

    // HALT is reported as legal-but-halting so DECODE can branch on one struct.
    function automatic op_dec_t decode_op(input logic [5:0] op);
        op_dec_t d;
        d.legal = 1'b1;
        d.halt  = 1'b0;
        d.cls   = CLS_ALU;
        case (op)
            OP_ALU_R, OP_ALU_I: d.cls  = CLS_ALU;
            OP_LW:              d.cls  = CLS_LW;
            OP_SW:              d.cls  = CLS_SW;
            OP_BR:              d.cls  = CLS_BR;
            OP_HALT:            d.halt = 1'b1;
            default:            d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/kgp_sequencer_timer.sv
// Memory wait counter: counts cycles without ready during one access and flags
// the cycle in which the MEM_TIMEOUT-th consecutive wait is being spent.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = 8;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // cnt_q holds the waits already spent, so this is the last allowed cycle.
    assign expired_o = (cnt_q == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/kgp_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through fetch, decode,
// execute, memory and write-back, issuing one-cycle datapath write strobes.
module kgp_sequencer
    import kgp_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_en,
    output logic             mem_we,
    output logic             ir_we,
    output logic             alu_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             busy,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] retired
);
    state_e          state_q, state_d;
    op_cls_e         cls_q, cls_d;
    logic [1:0]      err_q, err_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    op_dec_t         dec;
    logic            access, expired;

    assign dec    = decode_op(opcode);
    assign access = (state_q == S_FETCH) || (state_q == S_MEM);

    // Cleared whenever no access is pending or the current one completes, so
    // a MEM that retires straight into FETCH starts the next count at zero.
    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk_i    (clk),
        .rst_ni   (rst),
        .clr_i    (!access || mem_ready),
        .en_i     (access && !mem_ready),
        .expired_o(expired)
    );

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        err_d   = err_q;
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        ir_we   = 1'b0;
        alu_we  = 1'b0;
        rf_we   = 1'b0;
        pc_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_en = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (expired) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (dec.halt) begin
                    state_d = S_HALTED;
                end else if (!dec.legal) begin
                    state_d = S_ERROR;
                    err_d   = ERR_ILLEGAL;
                end else begin
                    cls_d   = dec.cls;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_we = 1'b1;
                case (cls_q)
                    CLS_BR: begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end
                    CLS_LW, CLS_SW: state_d = S_MEM;
                    default:        state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_en = 1'b1;
                if (mem_ready) begin
                    if (cls_q == CLS_SW) begin
                        mem_we  = 1'b1;
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (expired) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = state_q;
        endcase
        ret_d = ret_q + {{(CNT_W-1){1'b0}}, pc_we};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cls_q   <= CLS_ALU;
            err_q   <= ERR_NONE;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            err_q   <= err_d;
            ret_q   <= ret_d;
        end
    end

    assign busy    = !((state_q == S_IDLE) || (state_q == S_HALTED) || (state_q == S_ERROR));
    assign err     = err_q;
    assign retired = ret_q;

endmodule

// File: tb/tb_kgp_sequencer.sv
// Bench for kgp_sequencer: an instruction-level model expands each instruction
// into its expected per-cycle strobes, which drive stimulus and are checked.
module tb_kgp_sequencer;

    localparam logic [5:0] ALU_R = 6'b000000, ALU_I = 6'b000001, LW = 6'b000010;
    localparam logic [5:0] SW = 6'b000011, BR = 6'b000100, HALT = 6'b111111;
    // strobe vector order: mem_en mem_we ir_we alu_we rf_we pc_we busy
    localparam logic [6:0] EN = 7'b1000000, WE = 7'b0100000, IR = 7'b0010000;
    localparam logic [6:0] AL = 7'b0001000, RF = 7'b0000100, PC = 7'b0000010, BSY = 7'b0000001;

    typedef struct {
        logic       rdy;
        logic       st;
        logic [5:0] op;
        logic [6:0] exp;
        int         ret;
        logic [1:0] err;
    } cyc_t;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic mem_en0, mem_we0, ir_we0, alu_we0, rf_we0, pc_we0, busy0;
    logic mem_en4, mem_we4, ir_we4, alu_we4, rf_we4, pc_we4, busy4;
    logic [1:0] err0, err4;
    logic [31:0] ret0;
    logic [2:0] ret4;
    logic [6:0] obs0, obs4;

    always #5 clk = ~clk;

    kgp_sequencer dut0 (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .mem_ready(mem_ready),
        .mem_en(mem_en0), .mem_we(mem_we0), .ir_we(ir_we0), .alu_we(alu_we0),
        .rf_we(rf_we0), .pc_we(pc_we0), .busy(busy0), .err(err0), .retired(ret0)
    );

    kgp_sequencer #(.MEM_TIMEOUT(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .mem_ready(mem_ready),
        .mem_en(mem_en4), .mem_we(mem_we4), .ir_we(ir_we4), .alu_we(alu_we4),
        .rf_we(rf_we4), .pc_we(pc_we4), .busy(busy4), .err(err4), .retired(ret4)
    );

    assign obs0 = {mem_en0, mem_we0, ir_we0, alu_we0, rf_we0, pc_we0, busy0};
    assign obs4 = {mem_en4, mem_we4, ir_we4, alu_we4, rf_we4, pc_we4, busy4};

    int total = 0, bad = 0;
    int m_ret;
    logic [1:0] m_err;
    bit m_done;
    cyc_t q[$];
    int pc_cnt, we_cnt;

    task automatic push(input logic rdy, input logic st, input logic [5:0] op,
                        input logic [6:0] exp, input bit retire);
        cyc_t r;
        r.rdy = rdy; r.st = st; r.op = op; r.exp = exp; r.ret = m_ret; r.err = m_err;
        q.push_back(r);
        if (retire) m_ret++;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    // One memory access of w wait cycles under timeout T; fin is the ready cycle.
    task automatic access(input int w, input int t, input logic [6:0] fin,
                          input bit retire, output bit ok);
        for (int k = 0; k < w && k < t; k++) push(1'b0, rb(), rop(), EN | BSY, 1'b0);
        if (w >= t) begin
            m_err = 2'd2;
            m_done = 1'b1;
            ok = 1'b0;
        end else begin
            push(1'b1, rb(), rop(), fin, retire);
            ok = 1'b1;
        end
    endtask

    task automatic add_instr(input logic [5:0] op, input int fw, input int mw, input int t);
        bit ok;
        if (m_done) return;
        access(fw, t, EN | IR | BSY, 1'b0, ok);
        if (!ok) return;
        push(rb(), rb(), op, BSY, 1'b0);
        if (op == HALT) begin
            m_done = 1'b1;
            return;
        end
        if (!(op inside {ALU_R, ALU_I, LW, SW, BR})) begin
            m_err = 2'd1;
            m_done = 1'b1;
            return;
        end
        if (op == BR) begin
            push(rb(), rb(), rop(), AL | PC | BSY, 1'b1);
        end else if (op == LW || op == SW) begin
            push(rb(), rb(), rop(), AL | BSY, 1'b0);
            if (op == SW) access(mw, t, EN | WE | PC | BSY, 1'b1, ok);
            else access(mw, t, EN | BSY, 1'b0, ok);
            if (ok && op == LW) push(rb(), rb(), rop(), RF | PC | BSY, 1'b1);
        end else begin
            push(rb(), rb(), rop(), AL | BSY, 1'b0);
            push(rb(), rb(), rop(), RF | PC | BSY, 1'b1);
        end
    endtask

    task automatic push_start();
        push(rb(), 1'b1, rop(), 7'd0, 1'b0);
    endtask

    // Cycles after HALTED/ERROR, with start held high to show it is ignored.
    task automatic push_tail(input int n);
        for (int k = 0; k < n; k++) push(rb(), 1'b1, rop(), 7'd0, 1'b0);
    endtask

    task automatic run_q(input string name, input int sel, input int maxn);
        cyc_t r;
        logic [6:0] o;
        logic [31:0] oret, eret;
        logic [1:0] oerr;
        int n = 0;
        while (q.size() > 0 && n < maxn) begin
            r = q.pop_front();
            @(posedge clk);
            #1;
            mem_ready = r.rdy;
            start = r.st;
            opcode = r.op;
            @(negedge clk);
            o    = (sel == 4) ? obs4 : obs0;
            oret = (sel == 4) ? {29'd0, ret4} : ret0;
            eret = (sel == 4) ? (r.ret & 7) : r.ret;
            oerr = (sel == 4) ? err4 : err0;
            if (o[1]) pc_cnt++;
            if (o[5]) we_cnt++;
            total++;
            if (o !== r.exp) begin
                bad++;
                $display("FAIL %s cyc%0d strobes got %b want %b", name, n, o, r.exp);
            end
            total++;
            if (oret !== eret || oerr !== r.err) begin
                bad++;
                $display("FAIL %s cyc%0d retired/err got %0d/%0d want %0d/%0d",
                         name, n, oret, oerr, eret, r.err);
            end
            n++;
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({obs0, obs4} !== 14'd0) begin
            bad++;
            $display("FAIL %s strobes got %b/%b want all 0", name, obs0, obs4);
        end
        total++;
        if ({ret0, ret4, err0, err4} !== 39'd0) begin
            bad++;
            $display("FAIL %s retired/err got %0d,%0d/%0d,%0d want 0", name, ret0, ret4, err0, err4);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; mem_ready = 1'b0;
        #2 check_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        m_ret = 0; m_err = 2'd0; m_done = 1'b0;
        pc_cnt = 0; we_cnt = 0;
    endtask

    task automatic test_reset();
        #3 check_zero("reset_init");
        do_reset();
    endtask

    task automatic test_alu_r();
        do_reset();
        push_start();
        add_instr(ALU_R, 0, 0, 16);
        add_instr(HALT, 0, 0, 16);
        push_tail(2);
        run_q("alu_r", 0, 1000);
    endtask

    task automatic test_lw_wait();
        do_reset();
        push_start();
        add_instr(LW, 0, 3, 16);
        add_instr(HALT, 0, 0, 16);
        push_tail(2);
        run_q("lw_wait", 0, 1000);
    endtask

    task automatic test_sw_br_halt();
        do_reset();
        push_start();
        add_instr(SW, 0, 0, 16);
        add_instr(BR, 0, 0, 16);
        add_instr(HALT, 0, 0, 16);
        push_tail(4);
        run_q("sw_br_halt", 0, 1000);
        total++;
        if (we_cnt != 1 || pc_cnt != 2) begin
            bad++;
            $display("FAIL sw_br_halt pulses got mem_we=%0d pc_we=%0d want 1/2", we_cnt, pc_cnt);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        push_start();
        add_instr(6'b101010, 0, 0, 16);
        push_tail(3);
        run_q("illegal", 0, 1000);
    endtask

    task automatic test_timeout();
        do_reset();
        push_start();
        add_instr(ALU_R, 4, 0, 4);
        push_tail(3);
        run_q("timeout", 4, 1000);
        do_reset();
        push_start();
        add_instr(ALU_R, 3, 0, 4);
        add_instr(SW, 0, 3, 4);
        add_instr(LW, 0, 4, 4);
        push_tail(2);
        run_q("ready_last", 4, 1000);
    endtask

    task automatic test_mid_reset();
        do_reset();
        push_start();
        add_instr(ALU_R, 0, 0, 16);
        add_instr(SW, 0, 10, 16);
        run_q("mid_rst_pre", 0, 10);
        #2 rst = 1'b0;
        #1 check_zero("mid_rst");
        q.delete();
        do_reset();
    endtask

    task automatic test_random(input int sel, input int iters, input int t);
        logic [5:0] legal [5];
        logic [5:0] op;
        int n, fw, mw;
        legal[0] = ALU_R; legal[1] = ALU_I; legal[2] = LW; legal[3] = SW; legal[4] = BR;
        for (int it = 0; it < iters; it++) begin
            do_reset();
            push_start();
            n = $urandom_range(4, 12);
            for (int i = 0; i < n; i++) begin
                op = ($urandom_range(0, 19) == 0) ? 6'h20 + 6'($urandom_range(0, 15))
                                                  : legal[$urandom_range(0, 4)];
                fw = ($urandom_range(0, 15) == 0) ? $urandom_range(t - 2, t + 1) : $urandom_range(0, 3);
                mw = ($urandom_range(0, 15) == 0) ? $urandom_range(t - 2, t + 1) : $urandom_range(0, 3);
                add_instr(op, fw, mw, t);
            end
            add_instr(HALT, $urandom_range(0, 2), 0, t);
            push_tail(2);
            run_q((sel == 4) ? "random4" : "random16", sel, 5000);
        end
    endtask

    initial begin
        test_reset();
        test_alu_r();
        test_lw_wait();
        test_sw_br_halt();
        test_illegal();
        test_timeout();
        test_mid_reset();
        test_random(0, 8, 16);
        test_random(4, 8, 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
